// File: rtl/fifo_burst_reader.sv
// Read-side burst master: pops Len bytes from a 16x8 synchronous FIFO and
// streams them downstream through a 2-entry skid buffer that hides the read latency.
module fifo_burst_reader #(
  parameter int DW = 8,
  parameter int LW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Start,
  input  logic [LW-1:0] Len,
  output logic          Busy,
  output logic          Done,
  input  logic          Empty,
  output logic          R_en,
  input  logic [DW-1:0] R_data,
  output logic          O_valid,
  input  logic          O_ready,
  output logic [DW-1:0] O_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          infl_q, infl_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          head_q, head_d;
  logic          tail_q, tail_d;
  logic          done_q, done_d;
  logic [DW-1:0] obuf_q [2];

  logic [2:0]    occ;
  logic          xfer;
  logic          pop;

  // Occupancy counts the byte still in flight from the FIFO, so a pop is only
  // issued when a slot is guaranteed to be free by the time its data lands.
  assign occ     = {1'b0, cnt_q} + {2'b00, infl_q};
  assign O_valid = (cnt_q != 2'd0);
  assign O_data  = obuf_q[head_q];
  assign xfer    = O_valid & O_ready;
  assign Busy    = (state_q != IDLE);
  assign Done    = done_q;
  assign R_en    = pop;

  always_comb begin
    pop = (state_q == RUN) && !Empty && (rem_q != '0) &&
          ((occ < 3'd2) || ((occ == 3'd2) && xfer));
  end

  always_comb begin
    infl_d = pop;
    cnt_d  = cnt_q + 2'(infl_q) - 2'(xfer);
    head_d = head_q ^ xfer;
    tail_d = tail_q ^ infl_q;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (Len != '0) begin
            state_d = RUN;
            rem_d   = Len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (pop) begin
          rem_d = rem_q - LW'(1);
          if (rem_q == LW'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Leave only once nothing is in flight and the last byte is leaving now.
        if (!infl_q && (cnt_d == 2'd0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      infl_q  <= 1'b0;
      cnt_q   <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      infl_q  <= infl_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      obuf_q[0] <= '0;
      obuf_q[1] <= '0;
    end else if (infl_q) begin
      obuf_q[tail_q] <= R_data;
    end
  end

endmodule
